// File: rtl/data_path.sv
// data_path: 32-bit single-bus CPU datapath with 16 GPRs, special registers, a priority bus mux and a combinational ALU.
// Define DATAPATH_MULDIV_EN to build signed MUL/DIV; without it, opcodes 01010/01011 load Z with 0.
module data_path (
  input  logic        clock,
  input  logic        clear,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin,
  input  logic        Outport_in, Inport_in,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
  input  logic        IncPC,
  input  logic        Mem_read,
  input  logic [4:0]  opcode,
  input  logic [31:0] MDR_Mem_lines,
  input  logic [31:0] Inport_data_in,
  output logic [31:0] MAR_to_chip,
  output logic [31:0] Outport_data_out,
  output logic [31:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7,
  output logic [31:0] regMDR,
  output logic [31:0] BusMuxOut_out,
  output logic [31:0] PC_VALUE,
  output logic [31:0] HI_VALUE,
  output logic [31:0] LO_VALUE,
  output logic [31:0] IR_VALUE
);

  typedef enum logic [4:0] {
    OP_ADD, OP_AND, OP_OR, OP_SUB, OP_NEG, OP_SHR, OP_SHRA, OP_SHL,
    OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NOT
  } op_t;

  logic [15:0] r_in, r_out;
  logic [31:0] r [16];
  logic [31:0] pc, ir, mar, mdr, hi, lo, y, inport, outport;
  logic [63:0] z;
  logic [31:0] bus, a, b;
  logic [4:0]  sh;
  logic [31:0] ror_res, rol_res;
  logic [63:0] alu;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    bus = '0;
    if (|r_out) begin
      // Walk downwards so the lowest-numbered active register wins.
      for (int i = 15; i >= 0; i--)
        if (r_out[i]) bus = r[i];
    end
    else if (HIout)      bus = hi;
    else if (LOout)      bus = lo;
    else if (Zhi_out)    bus = z[63:32];
    else if (Zlo_out)    bus = z[31:0];
    else if (PCout)      bus = pc;
    else if (MDRout)     bus = mdr;
    else if (Inport_out) bus = inport;
    else if (Cout)       bus = {{13{ir[18]}}, ir[18:0]};
  end

  assign a  = y;
  assign b  = bus;
  assign sh = b[4:0];

  // A 32-bit operand shifted by 32 yields 0, which keeps the zero-rotate case correct.
  assign ror_res = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
  assign rol_res = (a << sh) | (a >> (6'd32 - {1'b0, sh}));

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] a_ext, b_ext, mul_res;
  logic [31:0] div_quo, div_rem;

  assign a_ext   = {{32{a[31]}}, a};
  assign b_ext   = {{32{b[31]}}, b};
  assign mul_res = a_ext * b_ext;
  assign div_quo = $signed(a) / $signed(b);
  assign div_rem = $signed(a) % $signed(b);
`endif

  always_comb begin
    alu = '0;
    case (opcode)
      OP_ADD:  alu[31:0] = a + b;
      OP_AND:  alu[31:0] = a & b;
      OP_OR:   alu[31:0] = a | b;
      OP_SUB:  alu[31:0] = a - b;
      OP_NEG:  alu[31:0] = -b;
      OP_NOT:  alu[31:0] = ~b;
      OP_SHR:  alu[31:0] = a >> sh;
      OP_SHRA: alu[31:0] = $signed(a) >>> sh;
      OP_SHL:  alu[31:0] = a << sh;
      OP_ROR:  alu[31:0] = ror_res;
      OP_ROL:  alu[31:0] = rol_res;
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:  alu = mul_res;
      OP_DIV:  if (b != '0) alu = {div_rem, div_quo};
`endif
      default: alu = '0;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples the pre-edge bus.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      // NOTE: the register file is cleared on reset too, so it is built from flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) r[i] <= '0;
      pc      <= '0;
      ir      <= '0;
      mar     <= '0;
      mdr     <= '0;
      hi      <= '0;
      lo      <= '0;
      y       <= '0;
      inport  <= '0;
      outport <= '0;
      z       <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (r_in[i]) r[i] <= bus;
      if (PCin)       pc      <= bus;
      if (IRin)       ir      <= bus;
      if (MARin)      mar     <= bus;
      if (HIin)       hi      <= bus;
      if (LOin)       lo      <= bus;
      if (RYin)       y       <= bus;
      if (Outport_in) outport <= bus;
      if (MDRin)      mdr     <= Mem_read ? MDR_Mem_lines : bus;
      if (Inport_in)  inport  <= Inport_data_in;
      if (RZin)       z       <= IncPC ? {32'b0, bus + 32'd1} : alu;
    end
  end

  assign MAR_to_chip      = mar;
  assign Outport_data_out = outport;
  assign reg1             = r[1];
  assign reg2             = r[2];
  assign reg3             = r[3];
  assign reg4             = r[4];
  assign reg5             = r[5];
  assign reg6             = r[6];
  assign reg7             = r[7];
  assign regMDR           = mdr;
  assign BusMuxOut_out    = bus;
  assign PC_VALUE         = pc;
  assign HI_VALUE         = hi;
  assign LO_VALUE         = lo;
  assign IR_VALUE         = ir;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path: load path, ALU ops, fetch, bus priority, MUL/DIV and async reset.
// Expectations for MUL/DIV follow DATAPATH_MULDIV_EN, so compile bench and RTL with the same macro setting.
module tb_data_path;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] rin, rout;
  logic        IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in;
  logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic        IncPC, Mem_read;
  logic [4:0]  opcode;
  logic [31:0] MDR_Mem_lines, Inport_data_in;
  logic [31:0] MAR_to_chip, Outport_data_out;
  logic [31:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [31:0] regMDR, BusMuxOut_out, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .MARin(MARin), .MDRin(MDRin),
    .HIin(HIin), .LOin(LOin), .Outport_in(Outport_in), .Inport_in(Inport_in),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
    .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
    .IncPC(IncPC), .Mem_read(Mem_read), .opcode(opcode),
    .MDR_Mem_lines(MDR_Mem_lines), .Inport_data_in(Inport_data_in),
    .MAR_to_chip(MAR_to_chip), .Outport_data_out(Outport_data_out),
    .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
    .regMDR(regMDR), .BusMuxOut_out(BusMuxOut_out), .PC_VALUE(PC_VALUE),
    .HI_VALUE(HI_VALUE), .LO_VALUE(LO_VALUE), .IR_VALUE(IR_VALUE)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    rin = '0; rout = '0;
    {IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in} = '0;
    {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout} = '0;
    IncPC = 1'b0; Mem_read = 1'b0; opcode = 5'b0;
  endtask

  // Apply the currently driven controls for one rising edge, then drop them.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic put_inport(input logic [31:0] value);
    Inport_data_in = value;
    Inport_in = 1'b1;
    tick();
  endtask

  // Shift/logic table, A = R2 = 0xFFFA0000, B = R3 = 0x14.
  localparam int NALU = 12;
  logic [4:0]  alu_op  [NALU] = '{5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b00000,
                                  5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01100, 5'b11111};
  logic [31:0] alu_exp [NALU] = '{32'h00000FFF, 32'hFFFFFFFF, 32'h00000000, 32'hA0000FFF,
                                  32'h000FFFA0, 32'hFFFA0014, 32'h00000000, 32'hFFFA0014,
                                  32'hFFF9FFEC, 32'hFFFFFFEC, 32'hFFFFFFEB, 32'h00000000};

  logic [31:0] mul_hi, mul_lo, div_hi, div_lo;

  initial begin
`ifdef DATAPATH_MULDIV_EN
    mul_hi = 32'hFFFFFFFF; mul_lo = 32'hFFFFFFFA; div_hi = 32'd1; div_lo = 32'd3;
`else
    mul_hi = 32'h0; mul_lo = 32'h0; div_hi = 32'h0; div_lo = 32'h0;
`endif
    idle();
    MDR_Mem_lines = '0;
    Inport_data_in = '0;
    clear = 1'b0;
    #12;
    check("reset pc", PC_VALUE, 32'h0);
    check("reset mdr", regMDR, 32'h0);
    check("reset bus", BusMuxOut_out, 32'h0);
    clear = 1'b1;

    // Memory load into MDR, then MDR onto the bus into R2 and PC.
    MDR_Mem_lines = 32'hFFFA0000; Mem_read = 1'b1; MDRin = 1'b1;
    tick();
    MDRout = 1'b1; rin[2] = 1'b1; PCin = 1'b1;
    tick();
    check("load mdr", regMDR, 32'hFFFA0000);
    check("load r2", reg2, 32'hFFFA0000);
    check("load pc", PC_VALUE, 32'hFFFA0000);

    put_inport(32'h14);
    Inport_out = 1'b1; rin[3] = 1'b1;
    tick();
    check("inport to r3", reg3, 32'h14);

    for (int i = 0; i < NALU; i++) begin
      rout[2] = 1'b1; RYin = 1'b1;
      tick();
      rout[3] = 1'b1; RZin = 1'b1; opcode = alu_op[i];
      tick();
      Zlo_out = 1'b1; rin[1] = 1'b1;
      tick();
      check($sformatf("alu op %b", alu_op[i]), reg1, alu_exp[i]);
    end

    // Same register as source and destination keeps its pre-edge value.
    rout[3] = 1'b1; rin[3] = 1'b1;
    tick();
    check("r3 self copy", reg3, 32'h14);
    rout[3] = 1'b1; Outport_in = 1'b1;
    tick();
    check("outport", Outport_data_out, 32'h14);

    // Fetch sequence starting at PC = 5.
    put_inport(32'd5);
    Inport_out = 1'b1; PCin = 1'b1;
    tick();
    PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; RZin = 1'b1;
    tick();
    Zlo_out = 1'b1; PCin = 1'b1;
    tick();
    MDR_Mem_lines = 32'h28918000; Mem_read = 1'b1; MDRin = 1'b1;
    tick();
    MDRout = 1'b1; IRin = 1'b1;
    tick();
    check("fetch mar", MAR_to_chip, 32'd5);
    check("fetch pc", PC_VALUE, 32'd6);
    check("fetch ir", IR_VALUE, 32'h28918000);
    Zhi_out = 1'b1; #1;
    check("incpc zhi", BusMuxOut_out, 32'h0);
    idle();

    // Bus priority and the sign-extended constant.
    Cout = 1'b1; #1;
    check("cout positive", BusMuxOut_out, 32'h00018000);
    rout[3] = 1'b1; rout[2] = 1'b1; HIout = 1'b1; #1;
    check("prio r2 over r3", BusMuxOut_out, 32'hFFFA0000);
    idle();
    MDRout = 1'b1; Inport_out = 1'b1; Cout = 1'b1; #1;
    check("prio mdr over inport", BusMuxOut_out, 32'h28918000);
    idle();
    MDR_Mem_lines = 32'h00040005; Mem_read = 1'b1; MDRin = 1'b1;
    tick();
    MDRout = 1'b1; IRin = 1'b1;
    tick();
    Cout = 1'b1; #1;
    check("cout negative", BusMuxOut_out, 32'hFFFC0005);
    idle();

    // MUL: -2 * 3.
    put_inport(32'hFFFFFFFE);
    Inport_out = 1'b1; RYin = 1'b1;
    tick();
    put_inport(32'd3);
    Inport_out = 1'b1; RZin = 1'b1; opcode = 5'b01010;
    tick();
    Zhi_out = 1'b1; HIin = 1'b1;
    tick();
    Zlo_out = 1'b1; LOin = 1'b1;
    tick();
    check("mul hi", HI_VALUE, mul_hi);
    check("mul lo", LO_VALUE, mul_lo);

    // DIV: 7 / 2, then 7 / 0.
    put_inport(32'd7);
    Inport_out = 1'b1; RYin = 1'b1;
    tick();
    put_inport(32'd2);
    Inport_out = 1'b1; RZin = 1'b1; opcode = 5'b01011;
    tick();
    Zhi_out = 1'b1; HIin = 1'b1;
    tick();
    Zlo_out = 1'b1; LOin = 1'b1;
    tick();
    check("div hi", HI_VALUE, div_hi);
    check("div lo", LO_VALUE, div_lo);
    put_inport(32'd0);
    Inport_out = 1'b1; RZin = 1'b1; opcode = 5'b01011;
    tick();
    Zhi_out = 1'b1; HIin = 1'b1;
    tick();
    Zlo_out = 1'b1; LOin = 1'b1;
    tick();
    check("div0 hi", HI_VALUE, 32'h0);
    check("div0 lo", LO_VALUE, 32'h0);

    // Asynchronous reset between edges, then blocked load while held.
    #2;
    clear = 1'b0;
    #1;
    check("rst reg1", reg1, 32'h0);
    check("rst reg2", reg2, 32'h0);
    check("rst reg3", reg3, 32'h0);
    check("rst mdr", regMDR, 32'h0);
    check("rst pc", PC_VALUE, 32'h0);
    check("rst ir", IR_VALUE, 32'h0);
    check("rst mar", MAR_to_chip, 32'h0);
    check("rst outport", Outport_data_out, 32'h0);
    check("rst bus", BusMuxOut_out, 32'h0);
    MDR_Mem_lines = 32'h12345678; Mem_read = 1'b1; MDRin = 1'b1;
    @(posedge clock);
    #1;
    check("load blocked in reset", regMDR, 32'h0);
    #2;
    clear = 1'b1;
    tick();
    check("first load after reset", regMDR, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 SHALL have ports: clock input 1 (all state updates on rising edge); clear input 1 (asynchronous, active-low reset).
REQ-002 SHALL have load enables, each input 1: R0in..R15in, IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in.
REQ-003 SHALL have bus-source selects, each input 1: R0out..R15out, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout.
REQ-004 SHALL have: IncPC input 1 (Z load = bus+1); Mem_read input 1 (MDR source select); opcode input 5 (ALU op).
REQ-005 SHALL have data inputs MDR_Mem_lines input 32 (memory read data) and Inport_data_in input 32.
REQ-006 SHALL have outputs MAR_to_chip output 32 (MAR value) and Outport_data_out output 32 (Outport value).
REQ-007 SHALL have observation outputs, each output 32: reg1..reg7 (R1..R7), regMDR, BusMuxOut_out, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE.

Function
REQ-008 SHALL hold 32-bit registers R0..R15, PC, IR, MAR, MDR, HI, LO, Y, Inport, Outport, plus a 64-bit Z register.
REQ-009 Each register SHALL load on the rising clock edge only while its enable is high; otherwise it holds.
REQ-010 R0..R15, PC, IR, MAR, HI, LO, Y, Outport SHALL load from BusMuxOut.
REQ-011 MDR SHALL load MDR_Mem_lines when Mem_read=1, else BusMuxOut.
REQ-012 Inport SHALL load Inport_data_in.
REQ-013 BusMuxOut SHALL be combinational, with selection priority R0out (highest) through R15out, then HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout.
REQ-014 If no select is high, BusMuxOut SHALL be 0.
REQ-015 Cout SHALL drive IR[18:0] sign-extended to 32 bits.
REQ-016 The ALU SHALL be combinational, with A=Y and B=BusMuxOut; Z loads the ALU result when RZin=1.
REQ-017 Opcode 00000 ADD: Zlo=A+B (mod 2^32), Zhi=0.
REQ-018 Opcode 00001 AND, 00010 OR: bitwise; Zhi=0.
REQ-019 Opcode 00011 SUB: Zlo=A-B; Zhi=0.
REQ-020 Opcode 00100 NEG: Zlo=-B; 01100 NOT: Zlo=~B; Zhi=0 for both.
REQ-021 Opcodes 00101 SHR (logical), 00110 SHRA (arithmetic), 00111 SHL: A shifted by B[4:0]; Zhi=0.
REQ-022 Opcodes 01000 ROR and 01001 ROL: A rotated by B[4:0]; Zhi=0.
REQ-023 Opcodes 01010 MUL and 01011 DIV SHALL behave per REQ-029/REQ-030.
REQ-024 Undefined opcodes SHALL produce Z=0.
REQ-025 When IncPC=1, the Z load value SHALL be {32'b0, BusMuxOut+1}, regardless of opcode.
REQ-026 When the same register is both bus source and destination in one cycle, it SHALL capture the pre-edge bus value.

Reset
REQ-027 When clear=0, all registers (including Z, PC, IR, MAR, MDR, Y, HI, LO, Inport, Outport) SHALL clear to 0 immediately, independent of clock.
REQ-028 While clear=0, all loads SHALL be blocked; the first load occurs on the first rising edge after clear=1.

Configuration
REQ-029 With DATAPATH_MULDIV_EN defined: MUL SHALL give Z = signed 64-bit A*B; DIV SHALL give Zlo = signed A/B and Zhi = A%B.
REQ-030 DIV with B=0 SHALL give Z=0; without DATAPATH_MULDIV_EN, opcodes 01010/01011 SHALL give Z=0.

Verification
REQ-031 Load path: MDR_Mem_lines=0xFFFA0000 with Mem_read=1, MDRin=1 for one edge, then MDRout=1, R2in=1, PCin=1 for one edge -> regMDR, reg2 and PC_VALUE all 0xFFFA0000.
REQ-032 Shift test setup: R2=0xFFFA0000, R3=0x14; sequence R2out+RYin, then R3out+RZin with the opcode under test, then Zlo_out+R1in.
REQ-033 Shift test results in reg1: SHR 00101 -> 0x00000FFF; SHRA 00110 -> 0xFFFFFFFF; SHL 00111 -> 0x00000000.
REQ-034 Fetch: PC=5; PCout+IncPC+MARin+RZin, then Zlo_out+PCin, then Mem_read+MDRin with 0x28918000, then MDRout+IRin -> MAR_to_chip=5, PC_VALUE=6, IR_VALUE=0x28918000.
REQ-035 MUL/DIV with macro defined: Y=0xFFFFFFFE, B=3, MUL -> Z=0xFFFFFFFF_FFFFFFFA; HIin via Zhi_out and LOin via Zlo_out give HI_VALUE=0xFFFFFFFF, LO_VALUE=0xFFFFFFFA. DIV 7/2 -> LO=3, HI=1. Without the macro -> 0.
REQ-036 Reset mid-operation: pull clear low between edges with registers loaded -> all observation outputs 0 at once; no select asserted -> BusMuxOut_out=0.
